// File: rtl/slave_port_arbiter.sv
// ============================================================================
// Module   : slave_port_arbiter
// Brief    : Round-robin arbiter and req/ack sequencer for one crossbar slave.
//            Optional slave-ack timeout enabled by SLAVE_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_port_arbiter #(
    parameter logic [1:0]  pSlave_Id = 2'd0,
    parameter logic [31:0] pTimeout  = 32'd16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [3:0]       master_req,
    input  logic [3:0][31:0] master_addr,
    input  logic [3:0]       master_cmd,
    input  logic [3:0][31:0] master_wdata,
    output logic [3:0]       master_ack,
    output logic [31:0]      master_rdata,
    output logic             slave_req,
    output logic             slave_cmd,
    output logic [31:0]      slave_wdata,
    input  logic             slave_ack,
    input  logic [31:0]      slave_rdata,
    output logic [3:0]       grant,
`ifdef SLAVE_ARB_TIMEOUT_EN
    output logic             busy,
    output logic             timeout_err
`else
    output logic             busy
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  rr_ptr_q;
    logic [3:0]  mask_q;
    logic [1:0]  win_q;
    logic [3:0]  master_ack_q;
    logic [31:0] master_rdata_q;
    logic        slave_req_q;
    logic        slave_cmd_q;
    logic [31:0] slave_wdata_q;
    logic [3:0]  grant_q;
    logic        busy_q;

    logic [3:0]  elig_d;
    logic        found_d;
    logic [1:0]  win_d;
    logic [1:0]  cand_d;

    // Only the slave-select bits of each address take part in arbitration.
    logic        unused_bits;
    assign unused_bits = ^{master_addr[0][29:0], master_addr[1][29:0],
                           master_addr[2][29:0], master_addr[3][29:0], pTimeout};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig_d[i] = master_req[i] && (master_addr[i][31:30] == pSlave_Id) && !mask_q[i];
        end
    end

    // Scan from the farthest offset down so the candidate nearest rr_ptr wins.
    always_comb begin
        found_d = 1'b0;
        win_d   = rr_ptr_q;
        cand_d  = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand_d = rr_ptr_q + 2'(k);
            if (elig_d[cand_d]) begin
                found_d = 1'b1;
                win_d   = cand_d;
            end
        end
    end

`ifdef SLAVE_ARB_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        timeout_err_q;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= 2'd0;
            mask_q         <= 4'd0;
            win_q          <= 2'd0;
            master_ack_q   <= 4'd0;
            master_rdata_q <= 32'd0;
            slave_req_q    <= 1'b0;
            slave_cmd_q    <= 1'b0;
            slave_wdata_q  <= 32'd0;
            grant_q        <= 4'd0;
            busy_q         <= 1'b0;
`ifdef SLAVE_ARB_TIMEOUT_EN
            cnt_q          <= 32'd0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    mask_q <= 4'd0;
                    if (found_d) begin
                        win_q         <= win_d;
                        slave_cmd_q   <= master_cmd[win_d];
                        slave_wdata_q <= master_wdata[win_d];
                        grant_q       <= 4'b0001 << win_d;
                        slave_req_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_BUSY;
`ifdef SLAVE_ARB_TIMEOUT_EN
                        cnt_q         <= 32'd0;
`endif
                    end
                end
                S_BUSY: begin
                    if (slave_ack) begin
                        slave_req_q    <= 1'b0;
                        master_ack_q   <= 4'b0001 << win_q;
                        master_rdata_q <= slave_rdata;
                        state_q        <= S_RELEASE;
`ifdef SLAVE_ARB_TIMEOUT_EN
                    end else if (cnt_q == pTimeout - 32'd1) begin
                        slave_req_q    <= 1'b0;
                        master_ack_q   <= 4'b0001 << win_q;
                        master_rdata_q <= 32'hDEAD_BEEF;
                        timeout_err_q  <= 1'b1;
                        state_q        <= S_RELEASE;
                    end else begin
                        cnt_q          <= cnt_q + 32'd1;
`endif
                    end
                end
                S_RELEASE: begin
                    master_ack_q <= 4'd0;
                    grant_q      <= 4'd0;
                    busy_q       <= 1'b0;
                    rr_ptr_q     <= win_q + 2'd1;
                    mask_q       <= 4'b0001 << win_q;
                    state_q      <= S_IDLE;
`ifdef SLAVE_ARB_TIMEOUT_EN
                    timeout_err_q <= 1'b0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign master_ack   = master_ack_q;
    assign master_rdata = master_rdata_q;
    assign slave_req    = slave_req_q;
    assign slave_cmd    = slave_cmd_q;
    assign slave_wdata  = slave_wdata_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
`ifdef SLAVE_ARB_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slave_port_arbiter.sv
// ============================================================================
// Module   : tb_slave_port_arbiter
// Brief    : Scoreboard bench for slave_port_arbiter (pSlave_Id = 0) with a
//            behavioural slave; timeout case built when SLAVE_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slave_port_arbiter;

    logic             iClk = 1'b0;
    logic             iRst;
    logic [3:0]       master_req;
    logic [3:0][31:0] master_addr;
    logic [3:0]       master_cmd;
    logic [3:0][31:0] master_wdata;
    logic [3:0]       master_ack;
    logic [31:0]      master_rdata;
    logic             slave_req;
    logic             slave_cmd;
    logic [31:0]      slave_wdata;
    logic             slave_ack;
    logic [31:0]      slave_rdata;
    logic [3:0]       grant;
    logic             busy;
`ifdef SLAVE_ARB_TIMEOUT_EN
    logic             timeout_err;
`endif

    always #5 iClk = ~iClk;

    slave_port_arbiter #(.pSlave_Id(2'd0), .pTimeout(32'd16)) u_dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .master_req   (master_req),
        .master_addr  (master_addr),
        .master_cmd   (master_cmd),
        .master_wdata (master_wdata),
        .master_ack   (master_ack),
        .master_rdata (master_rdata),
        .slave_req    (slave_req),
        .slave_cmd    (slave_cmd),
        .slave_wdata  (slave_wdata),
        .slave_ack    (slave_ack),
        .slave_rdata  (slave_rdata),
        .grant        (grant),
`ifdef SLAVE_ARB_TIMEOUT_EN
        .busy         (busy),
        .timeout_err  (timeout_err)
`else
        .busy         (busy)
`endif
    );

    typedef struct packed {
        logic [3:0]  ack;
        logic [31:0] rdata;
        logic        cmd;
        logic [31:0] wdata;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_mack = 0;
    int          slave_delay = 3;
    int          req_cnt = 0;
    int          sreq_cycles = 0;
    logic [3:0]  oneshot = 4'b1111;
    logic [3:0]  prev_ack = 4'd0;
    logic        last_cmd = 1'b0;
    logic [31:0] last_wdata = 32'd0;
    logic        seen_activity;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: behavioural slave, then scoreboard compare on master_ack.
    task automatic step();
        exp_t e;
        @(negedge iClk);
        slave_ack = 1'b0;
        if (slave_req) begin
            req_cnt++;
            sreq_cycles++;
            if (req_cnt >= slave_delay) begin
                slave_ack   = 1'b1;
                slave_rdata = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'd0;
                last_cmd    = slave_cmd;
                last_wdata  = slave_wdata;
                req_cnt     = 0;
            end
        end else begin
            req_cnt = 0;
        end
        if (master_ack != 4'd0) begin
            n_mack++;
            chk("ack_single_pulse", {28'd0, prev_ack}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {28'd0, master_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_onehot", {28'd0, master_ack}, {28'd0, e.ack});
                chk("rdata", master_rdata, e.rdata);
                chk("grant_at_ack", {28'd0, grant}, {28'd0, e.ack});
                chk("slave_cmd", {31'd0, last_cmd}, {31'd0, e.cmd});
                chk("slave_wdata", last_wdata, e.wdata);
`ifdef SLAVE_ARB_TIMEOUT_EN
                chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
`endif
            end
            master_req = master_req & ~(master_ack & oneshot);
        end
        prev_ack = master_ack;
    endtask

    task automatic run_acks(input int target, input int budget);
        int cyc = 0;
        while (n_mack < target && cyc < budget) begin
            step();
            cyc++;
        end
        chk("ack_wait", n_mack, target);
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        step();
        step();
        iRst = 1'b0;
    endtask

    task automatic expect_txn(input logic [3:0] ack, input logic [31:0] rd,
                              input logic cmd, input logic [31:0] wd);
        rsp_q.push_back(rd);
        exp_q.push_back({ack, rd, cmd, wd, 1'b0});
    endtask

    initial begin
        iRst         = 1'b1;
        master_req   = 4'd0;
        master_addr  = '0;
        master_cmd   = 4'd0;
        master_wdata = '0;
        slave_ack    = 1'b0;
        slave_rdata  = 32'd0;
        step();
        step();
        chk("rst_master_ack", {28'd0, master_ack}, 32'd0);
        chk("rst_master_rdata", master_rdata, 32'd0);
        chk("rst_slave_req", {31'd0, slave_req}, 32'd0);
        chk("rst_slave_cmd", {31'd0, slave_cmd}, 32'd0);
        chk("rst_slave_wdata", slave_wdata, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        iRst = 1'b0;
        step();

        // Single master read, slave answers after three cycles.
        oneshot = 4'b1111;
        slave_delay = 3;
        sreq_cycles = 0;
        master_addr[0] = 32'h0000_0010;
        master_cmd[0]  = 1'b0;
        expect_txn(4'b0001, 32'h1234_5678, 1'b0, 32'd0);
        master_req[0] = 1'b1;
        step();
        chk("single_grant", {28'd0, grant}, 32'h1);
        chk("single_busy", {31'd0, busy}, 32'h1);
        run_acks(1, 20);
        chk("single_sreq_cycles", sreq_cycles, 3);
        step();
        chk("single_grant_idle", {28'd0, grant}, 32'd0);
        chk("single_busy_idle", {31'd0, busy}, 32'd0);

        // Round-robin with all four masters requesting continuously.
        do_reset();
        oneshot = 4'b0000;
        slave_delay = 1;
        for (int i = 0; i < 4; i++) begin
            master_addr[i]  = 32'h0000_0100 * (i + 1);
            master_cmd[i]   = 1'b0;
            master_wdata[i] = 32'h1000_0000 + i;
        end
        expect_txn(4'b0001, 32'hA000_0001, 1'b0, 32'h1000_0000);
        expect_txn(4'b0010, 32'hA000_0002, 1'b0, 32'h1000_0001);
        expect_txn(4'b0100, 32'hA000_0003, 1'b0, 32'h1000_0002);
        expect_txn(4'b1000, 32'hA000_0004, 1'b0, 32'h1000_0003);
        expect_txn(4'b0001, 32'hA000_0005, 1'b0, 32'h1000_0000);
        master_req = 4'b1111;
        run_acks(n_mack + 5, 60);
        master_req = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        chk("rr_queue_drained", exp_q.size(), 0);
        chk("rr_grant_idle", {28'd0, grant}, 32'd0);

        // Address filter: master 2 targets slave 1.
        do_reset();
        master_addr[1] = 32'h4000_0000;
        master_req = 4'b0010;
        seen_activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant != 4'd0 || slave_req) seen_activity = 1'b1;
        end
        chk("filter_no_grant", {31'd0, seen_activity}, 32'd0);
        master_req = 4'b0000;

        // Write path: wdata latched at grant, later input changes ignored.
        do_reset();
        oneshot = 4'b1111;
        slave_delay = 5;
        master_addr[2]  = 32'h0000_0020;
        master_cmd[2]   = 1'b1;
        master_wdata[2] = 32'hCAFE_F00D;
        expect_txn(4'b0100, 32'h0BAD_0001, 1'b1, 32'hCAFE_F00D);
        master_req = 4'b0100;
        step();
        step();
        chk("wr_slave_cmd", {31'd0, slave_cmd}, 32'h1);
        chk("wr_slave_wdata", slave_wdata, 32'hCAFE_F00D);
        master_wdata[2] = 32'd0;
        step();
        step();
        chk("wr_wdata_held", slave_wdata, 32'hCAFE_F00D);
        run_acks(n_mack + 1, 20);
        step();
        step();

        // Reset mid-transaction; rr_ptr is 3 here, so master 4 wins first.
        slave_delay = 100;
        master_addr[0] = 32'h0000_0030;
        master_addr[3] = 32'h0000_0040;
        master_cmd[0]  = 1'b0;
        master_cmd[3]  = 1'b0;
        master_wdata[0] = 32'h0000_0000;
        master_wdata[3] = 32'h3333_3333;
        master_req = 4'b1001;
        step();
        step();
        chk("pre_rst_grant", {28'd0, grant}, 32'h8);
        iRst = 1'b1;
        step();
        chk("midrst_slave_req", {31'd0, slave_req}, 32'd0);
        chk("midrst_grant", {28'd0, grant}, 32'd0);
        chk("midrst_master_ack", {28'd0, master_ack}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        iRst = 1'b0;
        slave_delay = 2;
        expect_txn(4'b0001, 32'h5555_0001, 1'b0, 32'h0000_0000);
        expect_txn(4'b1000, 32'h5555_0002, 1'b0, 32'h3333_3333);
        run_acks(n_mack + 2, 40);
        chk("midrst_queue_drained", exp_q.size(), 0);

`ifdef SLAVE_ARB_TIMEOUT_EN
        // Slave never answers: abort after sixteen BUSY cycles.
        do_reset();
        slave_delay = 1000;
        sreq_cycles = 0;
        master_addr[0]  = 32'h0000_0050;
        master_cmd[0]   = 1'b0;
        master_wdata[0] = 32'd0;
        exp_q.push_back({4'b0001, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1});
        master_req = 4'b0001;
        run_acks(n_mack + 1, 40);
        chk("to_busy_cycles", sreq_cycles, 16);
        step();
        chk("to_err_cleared", {31'd0, timeout_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slave_port_arbiter.md
Name: slave_port_arbiter

Overview:
- Per-slave arbitration and sequencing unit for the 4x4 crossbar; one instance per slave port.
- Selects one of four masters whose request targets this slave (addr[31:30] == pSlave_Id) using round-robin.
- Holds the grant for a full req/ack transaction, muxes cmd/wdata to the slave and returns ack/rdata to the winner.
- Sits inside the crossbar control path, between the master-side buses and one Slave instance.

Parameters:
- pSlave_Id, 2'd0, slave index this arbiter serves; compared against master addr[31:30].
- pTimeout, 32'd16, cycles to wait for slave_ack before abort (used only with the optional feature).

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset; synchronous, active-high.
- master_req  in  4  per-master request, bit i = master i+1; held high until that master sees its ack.
- master_addr  in  4x32  per-master address; bits [31:30] select the slave.
- master_cmd  in  4  per-master operation (1 = write, 0 = read).
- master_wdata  in  4x32  per-master write data.
- master_ack  out  4  one-hot, one-cycle ack to the granted master.
- master_rdata  out  32  read data; valid only in the cycle master_ack is high.
- slave_req  out  1  request to the slave.
- slave_cmd  out  1  latched cmd of the granted master.
- slave_wdata  out  32  latched wdata of the granted master.
- slave_ack  in  1  one-cycle ack from the slave.
- slave_rdata  in  32  slave read data; valid with slave_ack.
- grant  out  4  one-hot current owner; 0 when idle.
- busy  out  1  high in states BUSY and RELEASE.

Behaviour:
- All outputs are registered.
- Reset values: master_ack = 0, master_rdata = 0, slave_req = 0, slave_cmd = 0, slave_wdata = 0, grant = 0, busy = 0.
- Reset internal state: state = IDLE, rr_ptr = 0 (master 1 has highest priority first), mask = 0.
- Eligible set: elig[i] = master_req[i] && master_addr[i][31:30] == pSlave_Id && !mask[i].
- Round-robin: search elig starting at index rr_ptr, wrapping 3 -> 0; the first set bit wins.
- IDLE:
  - If elig == 0, stay in IDLE.
  - Otherwise latch the winner index w, its cmd and its wdata; set grant = onehot(w) and slave_req = 1; go to BUSY.
  - The mask register clears in IDLE after one cycle.
- BUSY:
  - slave_req stays 1, and slave_cmd/slave_wdata stay stable.
  - Input changes on any master are ignored.
  - On slave_ack: slave_req <= 0, master_ack[w] <= 1, master_rdata <= slave_rdata; go to RELEASE.
- RELEASE (exactly one cycle):
  - master_ack[w] is high during this cycle.
  - Exiting: master_ack <= 0, grant <= 0, rr_ptr <= (w+1) mod 4, mask <= onehot(w); go to IDLE.
- Mask rule: the previous winner is ineligible for the first IDLE cycle after RELEASE. This absorbs the winner's registered req deassert and prevents a double-serve.
- Latency, no contention: req sampled at edge k -> slave_req high after edge k (ack at slave side after edge k+D) -> master_ack high one cycle after slave_ack is sampled.
- Minimum transaction: 3 cycles (IDLE, BUSY, RELEASE).
- slave_ack outside BUSY is ignored.
- A master whose req drops while it is granted is not tracked; the transaction completes normally.
- Writes: master_rdata still captures slave_rdata on ack, and the value is don't-care.
- iRst in any state returns all outputs to reset values on the next edge; an in-flight transaction is dropped with no ack.

Optional Feature:
- Macro: SLAVE_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to BUSY and increments each cycle in BUSY.
  - When the counter reaches pTimeout - 1 without slave_ack: abort, go to RELEASE with master_ack[w] = 1, master_rdata = 32'hDEAD_BEEF, slave_req <= 0; rr_ptr and mask update as normal.
  - A 1-bit output timeout_err pulses high in the same cycle as that ack. It is reset to 0.
- Undefined: no counter and no timeout_err port; BUSY waits for slave_ack indefinitely.

Test Plan:
- Single master: master 1 reads addr 32'h0000_0010 on pSlave_Id 0; slave acks with rdata 32'h1234_5678 three cycles later -> slave_req high for 3 cycles, master_ack[0] single pulse, master_rdata = 32'h1234_5678, grant 4'b0001 then 0.
- Round-robin fairness: all four masters request slave 0 continuously -> grant order 0001, 0010, 0100, 1000, 0001; no master is served twice in a row.
- Address filter: master 2 requests addr 32'h4000_0000 on a pSlave_Id 0 instance -> grant stays 0, slave_req stays 0.
- Write path: master 3 writes 32'hCAFE_F00D; master 3 changes wdata to 0 mid-BUSY -> slave_wdata holds 32'hCAFE_F00D until ack; slave_cmd = 1.
- Reset mid-transaction: iRst asserted during BUSY -> next cycle slave_req = 0, grant = 0, no master_ack; after release, master 1 wins first (rr_ptr = 0).
- With SLAVE_ARB_TIMEOUT_EN and pTimeout = 16: slave never acks -> after 16 BUSY cycles master_ack pulses, master_rdata = 32'hDEAD_BEEF, timeout_err = 1 for one cycle.
